// File: rtl/lcd_ram_scanner_if.sv
// RAM read port between the character RAM and the LCD scanner.
// Read data is valid one clk2 edge after the edge that sampled ram_rd.
interface lcd_ram_scanner_if;
    logic       ram_rd;
    logic [7:0] ram_addr;
    logic [7:0] ram_data;

    modport master (
        output ram_rd,
        output ram_addr,
        input  ram_data
    );

    modport slave (
        input  ram_rd,
        input  ram_addr,
        output ram_data
    );
endinterface

// File: rtl/lcd_ram_scanner.sv
// Scans 32 character bytes from RAM onto a 16x2 HD44780 LCD bus.
// Runs the power-on init once, then one full refresh per start pulse.
module lcd_ram_scanner #(
    parameter logic [7:0]  BASE_ADDR = 8'h00,
    parameter int unsigned T_PWR     = 750000,
    parameter int unsigned T_EN      = 12,
    parameter int unsigned T_CMD     = 2500,
    parameter int unsigned T_CLR     = 82000
) (
    input  logic               clk2,
    input  logic               rst,
    input  logic               start,
    lcd_ram_scanner_if.master  ram,
    output logic               lcd_rs,
    output logic               lcd_rw,
    output logic               lcd_e,
    output logic [7:0]         lcd_db,
    output logic               busy,
    output logic               frame_done
);

    localparam int unsigned T_A   = (T_PWR > T_CLR) ? T_PWR : T_CLR;
    localparam int unsigned T_B   = (T_A > T_CMD) ? T_A : T_CMD;
    localparam int unsigned T_MAX = (T_B > T_EN) ? T_B : T_EN;
    localparam int          CW    = $clog2(T_MAX + 1);

    typedef enum logic [3:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        LINE_CMD,
        FETCH,
        CAPTURE,
        SETUP,
        E_HIGH,
        E_WAIT,
        DONE
    } state_t;

    state_t          r_state;
    state_t          r_ret;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_init_idx;
    logic            r_line;
    logic [3:0]      r_col;
    logic            r_ram_rd;
    logic [7:0]      r_ram_addr;
    logic            r_rs;
    logic            r_e;
    logic [7:0]      r_db;
    logic            r_busy;
    logic            r_done;

    logic [CW-1:0]   w_wait_end;
    logic [7:0]      w_next_cmd;

    // Only the clear command (rs=0) needs the long settle time
    assign w_wait_end = (!r_rs && r_db == 8'h01) ? CW'(T_CLR - 1)
                                                  : CW'(T_CMD - 1);

    always_comb begin
        w_next_cmd = 8'h38;
        unique case (r_init_idx)
            2'd0:    w_next_cmd = 8'h0C;
            2'd1:    w_next_cmd = 8'h01;
            2'd2:    w_next_cmd = 8'h06;
            default: w_next_cmd = 8'h38;
        endcase
    end

    always_ff @(posedge clk2) begin
        if (!rst) begin
            r_state    <= PWR_WAIT;
            r_ret      <= INIT;
            r_cnt      <= '0;
            r_init_idx <= 2'd0;
            r_line     <= 1'b0;
            r_col      <= 4'd0;
            r_ram_rd   <= 1'b0;
            r_ram_addr <= BASE_ADDR;
            r_rs       <= 1'b0;
            r_e        <= 1'b0;
            r_db       <= 8'h00;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                PWR_WAIT: begin
                    if (r_cnt == CW'(T_PWR - 1)) begin
                        r_cnt      <= '0;
                        r_init_idx <= 2'd0;
                        r_db       <= 8'h38;
                        r_rs       <= 1'b0;
                        r_ret      <= INIT;
                        r_state    <= SETUP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_line  <= 1'b0;
                        r_col   <= 4'd0;
                        r_state <= LINE_CMD;
                    end
                end
                LINE_CMD: begin
                    r_db    <= r_line ? 8'hC0 : 8'h80;
                    r_rs    <= 1'b0;
                    r_ret   <= LINE_CMD;
                    r_state <= SETUP;
                end
                FETCH: begin
                    r_ram_rd <= 1'b0;
                    r_state  <= CAPTURE;
                end
                CAPTURE: begin
                    r_db    <= ram.ram_data;
                    r_rs    <= 1'b1;
                    r_ret   <= CAPTURE;
                    r_state <= SETUP;
                end
                SETUP: begin
                    r_e     <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= E_HIGH;
                end
                E_HIGH: begin
                    if (r_cnt == CW'(T_EN - 1)) begin
                        r_e     <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= E_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                E_WAIT: begin
                    if (r_cnt == w_wait_end) begin
                        r_cnt <= '0;
                        // Return to whichever phase issued this transfer
                        unique case (r_ret)
                            INIT: begin
                                if (r_init_idx == 2'd3) begin
                                    r_busy  <= 1'b0;
                                    r_state <= IDLE;
                                end else begin
                                    r_init_idx <= r_init_idx + 2'd1;
                                    r_db       <= w_next_cmd;
                                    r_state    <= SETUP;
                                end
                            end
                            LINE_CMD: begin
                                r_ram_rd   <= 1'b1;
                                r_ram_addr <= BASE_ADDR
                                            + {3'b000, r_line, 4'h0};
                                r_state    <= FETCH;
                            end
                            default: begin
                                if (r_col != 4'hF) begin
                                    r_col      <= r_col + 4'd1;
                                    r_ram_rd   <= 1'b1;
                                    r_ram_addr <= BASE_ADDR
                                                + {3'b000, r_line,
                                                   r_col + 4'd1};
                                    r_state    <= FETCH;
                                end else if (!r_line) begin
                                    r_line  <= 1'b1;
                                    r_col   <= 4'd0;
                                    r_state <= LINE_CMD;
                                end else begin
                                    r_done  <= 1'b1;
                                    r_state <= DONE;
                                end
                            end
                        endcase
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= PWR_WAIT;
            endcase
        end
    end

    assign ram.ram_rd   = r_ram_rd;
    assign ram.ram_addr = r_ram_addr;
    assign lcd_rs       = r_rs;
    assign lcd_rw       = 1'b0;
    assign lcd_e        = r_e;
    assign lcd_db       = r_db;
    assign busy         = r_busy;
    assign frame_done   = r_done;

endmodule

// File: tb/tb_lcd_ram_scanner.sv
// Randomized bench for lcd_ram_scanner against a frame-level model.
// Checks init sequence timing, frame contents, addresses and aborts.
module tb_lcd_ram_scanner;

    localparam logic [7:0]  BASE  = 8'hF0;
    localparam int unsigned T_PWR = 20;
    localparam int unsigned T_EN  = 3;
    localparam int unsigned T_CMD = 10;
    localparam int unsigned T_CLR = 30;

    logic       clk2  = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic       lcd_rs, lcd_rw, lcd_e, busy, frame_done;
    logic [7:0] lcd_db;

    lcd_ram_scanner_if ram_if ();

    lcd_ram_scanner #(
        .BASE_ADDR (BASE),
        .T_PWR     (T_PWR),
        .T_EN      (T_EN),
        .T_CMD     (T_CMD),
        .T_CLR     (T_CLR)
    ) dut (
        .clk2       (clk2),
        .rst        (rst),
        .start      (start),
        .ram        (ram_if),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_e      (lcd_e),
        .lcd_db     (lcd_db),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk2 = ~clk2;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk2) cyc <= cyc + 1;

    logic [7:0] mem [256];

    always @(posedge clk2)
        if (ram_if.ram_rd === 1'b1)
            ram_if.ram_data <= mem[ram_if.ram_addr];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     tag, got, exp, cyc);
        end
    endtask

    // Bus monitor
    logic [8:0] xq [$];
    int         xt [$];
    logic [7:0] aq [$];
    int         fd_cnt = 0;
    int         fd_cyc = 0;
    int         c0_at  = -1;
    logic       pe, prd, pfd;
    logic [8:0] pbus;
    int         ew = 0;
    int         rdw = 0;
    bit         ew_ok = 0;

    always @(negedge clk2) begin
        if (rst !== 1'b1) ew_ok = 0;
        if (lcd_e === 1'b1) begin
            if (pe !== 1'b1) begin
                xq.push_back({lcd_rs, lcd_db});
                xt.push_back(cyc);
                if ({lcd_rs, lcd_db} === 9'h0C0) c0_at = aq.size();
                ew = 1;
                ew_ok = 1;
            end else begin
                ew++;
                chk("bus_stable", {lcd_rs, lcd_db}, pbus);
            end
        end else if (pe === 1'b1 && ew_ok) begin
            chk("e_width", ew, T_EN);
        end
        if (ram_if.ram_rd === 1'b1) begin
            if (prd !== 1'b1) aq.push_back(ram_if.ram_addr);
            rdw++;
            chk("rd_busy", busy, 1);
        end else if (prd === 1'b1) begin
            chk("rd_width", rdw, 1);
            rdw = 0;
        end
        chk("rw_zero", lcd_rw, 0);
        if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (pfd === 1'b1) chk("busy_after_done", busy, 0);
        pe   = lcd_e;
        prd  = ram_if.ram_rd;
        pfd  = frame_done;
        pbus = {lcd_rs, lcd_db};
    end

    task automatic clear_mon();
        xq.delete();
        xt.delete();
        aq.delete();
        c0_at = -1;
    endtask

    // Call at a negedge; leaves reset released, r = last reset edge
    task automatic do_reset(input int hold, output int r);
        #2;
        rst   = 1'b0;
        start = 1'b0;
        repeat (hold) @(negedge clk2);
        chk("rst_e", lcd_e, 0);
        chk("rst_busy", busy, 1);
        chk("rst_rd", ram_if.ram_rd, 0);
        chk("rst_addr", ram_if.ram_addr, BASE);
        chk("rst_db", lcd_db, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_rw", lcd_rw, 0);
        #2;
        rst = 1'b1;
        clear_mon();
        r = cyc;
    endtask

    task automatic check_init(input int r, input int sp);
        logic [7:0] cmd [4];
        int t, n;
        cmd[0] = 8'h38; cmd[1] = 8'h0C; cmd[2] = 8'h01; cmd[3] = 8'h06;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk2);
            n++;
            if (sp > 0 && n == sp) begin #2; start = 1'b1; end
            else if (sp > 0 && n == sp + 1) begin #2; start = 1'b0; end
        end
        start = 1'b0;
        chk("init_done", busy, 0);
        chk("init_count", xq.size(), 4);
        t = r + T_PWR + 1;
        for (int k = 0; k < 4 && k < xq.size(); k++) begin
            chk("init_cmd", xq[k], {1'b0, cmd[k]});
            chk("init_rise", xt[k], t);
            t += 1 + T_EN + ((cmd[k] == 8'h01) ? T_CLR : T_CMD);
        end
        chk("busy_fall", cyc, t - 1);
        chk("init_no_rd", aq.size(), 0);
    endtask

    int offs [34];
    int offa [34];

    task automatic run_frame(input bit fixed, input int extra,
                             input bit b2b);
        logic [8:0] ex [$];
        int s, n, f0;
        for (int i = 0; i < 32; i++)
            mem[(BASE + i) % 256] = fixed ? 8'(8'h41 + i)
                                          : 8'($urandom);
        ex.push_back(9'h080);
        for (int i = 0; i < 16; i++)
            ex.push_back({1'b1, mem[(BASE + i) % 256]});
        ex.push_back(9'h0C0);
        for (int i = 16; i < 32; i++)
            ex.push_back({1'b1, mem[(BASE + i) % 256]});
        if (b2b) while (cyc < fd_cyc + 1) @(negedge clk2);
        else @(negedge clk2);
        clear_mon();
        f0 = fd_cnt;
        #2;
        start = 1'b1;
        s = cyc + 1;
        @(negedge clk2);
        #2;
        start = 1'b0;
        chk("busy_on_start", busy, 1);
        n = 0;
        while (fd_cnt == f0 && n < 5000) begin
            @(negedge clk2);
            n++;
            if (extra > 0 && n == extra) begin #2; start = 1'b1; end
            else if (extra > 0 && n == extra + 1) begin #2; start = 1'b0; end
        end
        start = 1'b0;
        chk("frame_done", fd_cnt - f0, 1);
        chk("xfer_count", xq.size(), 34);
        for (int i = 0; i < 34 && i < xq.size(); i++) begin
            chk("xfer", xq[i], ex[i]);
            offs[i] = xt[i] - s;
        end
        chk("rd_count", aq.size(), 32);
        for (int i = 0; i < 32 && i < aq.size(); i++)
            chk("rd_addr", aq[i], (BASE + i) % 256);
        chk("c0_order", c0_at, 16);
    endtask

    initial begin
        int r, n, f0;
        // Power-on init, with a start pulse that must be dropped
        do_reset(3, r);
        check_init(r, 25);
        repeat (30) @(negedge clk2);
        chk("no_frame_from_init_start", xq.size(), 4);
        chk("idle_busy", busy, 0);

        // Known pattern plus a start pulse five cycles into the frame
        f0 = fd_cnt;
        run_frame(1'b1, 5, 1'b0);
        repeat (60) @(negedge clk2);
        chk("no_extra_xfer", xq.size(), 34);
        chk("no_extra_frame", fd_cnt - f0, 1);

        // Back-to-back random frames with identical timing
        run_frame(1'b0, 0, 1'b0);
        offa = offs;
        run_frame(1'b0, 0, 1'b1);
        for (int i = 0; i < 34; i++) chk("b2b_timing", offs[i], offa[i]);
        run_frame(1'b0, 0, 1'b1);

        // Reset while lcd_e is high on a data byte
        repeat (5) @(negedge clk2);
        #2;
        start = 1'b1;
        @(negedge clk2);
        #2;
        start = 1'b0;
        n = 0;
        while (!(lcd_e === 1'b1 && lcd_rs === 1'b1) && n < 5000) begin
            @(negedge clk2);
            n++;
        end
        chk("abort_pre", lcd_e, 1);
        f0 = fd_cnt;
        do_reset(1, r);
        check_init(r, 0);
        repeat (60) @(negedge clk2);
        chk("abort_no_data", xq.size(), 4);
        chk("abort_no_frame", fd_cnt - f0, 0);

        run_frame(1'b0, 0, 1'b0);

        repeat (5) @(negedge clk2);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/lcd_ram_scanner.md
Name: lcd_ram_scanner

Overview:
- Downstream consumer of the wb_lcd character RAM.
- Reads 32 character bytes out of the RAM read port and drives a 16x2 HD44780-compatible LCD over its 8-bit parallel bus.
- Runs the power-on init sequence once after reset, then refreshes the whole screen once per start request.
- Generates all LCD enable and settle timing from clk2.

Parameters:
- BASE_ADDR, 8'h00: RAM address of the first character (line 1, column 0).
- T_PWR, 750000: clk2 cycles of idle after reset before the first init command (15 ms at 50 MHz).
- T_EN, 12: clk2 cycles that lcd_e is held high per transfer.
- T_CMD, 2500: clk2 cycles of wait after lcd_e falls, for normal commands and data (50 us).
- T_CLR, 82000: clk2 cycles of wait after lcd_e falls for the clear command (1.64 ms).

Ports:
- clk2  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to refresh the screen.
- ram_rd  out  1  read strobe to the RAM read port.
- ram_addr  out  8  RAM read address.
- ram_data  in  8  RAM read data; valid on the first clk2 edge after the edge that sampled ram_rd=1.
- lcd_rs  out  1  0 = command, 1 = data.
- lcd_rw  out  1  constant 0 (write-only).
- lcd_e  out  1  LCD enable strobe.
- lcd_db  out  8  LCD data bus.
- busy  out  1  high during init and during a refresh.
- frame_done  out  1  one-cycle pulse when a refresh completes.

Behaviour:
- Reset (rst=0 sampled on a clk2 edge):
  - Outputs go to: ram_rd=0, ram_addr=BASE_ADDR, lcd_rs=0, lcd_rw=0, lcd_e=0, lcd_db=8'h00, busy=1, frame_done=0.
  - All counters clear and the state machine goes to PWR_WAIT.
  - Reset asserted in any state, including mid-transfer with lcd_e high, aborts on that edge. The full init sequence reruns after release.
- States: PWR_WAIT, INIT, IDLE, LINE_CMD, FETCH, CAPTURE, then the transfer sub-sequence SETUP, E_HIGH, E_WAIT, then DONE.
- Transfer sub-sequence (used for every command and every data byte):
  - SETUP: 1 cycle. lcd_rs and lcd_db are driven; lcd_e=0.
  - E_HIGH: T_EN cycles with lcd_e=1. lcd_rs and lcd_db are held stable.
  - E_WAIT: lcd_e=0 for T_CMD cycles, or T_CLR cycles if the byte was the clear command 8'h01. lcd_db and lcd_rs are held.
  - Total length is 1+T_EN+T_CMD cycles (or 1+T_EN+T_CLR for clear).
- PWR_WAIT: counts T_PWR cycles, then enters INIT.
- INIT: sends these commands in order with lcd_rs=0: 8'h38, 8'h0C, 8'h01, 8'h06. Then enters IDLE.
  - busy falls on the cycle IDLE is entered.
  - start pulses received before IDLE is reached are ignored, not queued.
- IDLE: busy=0. When start=1 is sampled, busy=1 on the next cycle and the block enters LINE_CMD with line=0 and col=0.
- LINE_CMD: sends command 8'h80 for line 0 or 8'hC0 for line 1, then goes to FETCH.
- FETCH: 1 cycle.
  - ram_rd=1.
  - ram_addr = (BASE_ADDR + 16*line + col) mod 256; the 8-bit add wraps, so 8'hFF+1 = 8'h00.
- CAPTURE: 1 cycle.
  - ram_rd=0.
  - ram_data is registered into lcd_db with lcd_rs=1.
  - ram_addr holds its value until the next FETCH.
- After each data transfer, col increments.
  - col<16: back to FETCH.
  - col=16 with line=0: line=1, col=0, go to LINE_CMD.
  - col=16 with line=1: go to DONE.
- DONE: 1 cycle with frame_done=1. busy=0 from the next cycle and the block returns to IDLE.
- ram_rd rules:
  - ram_rd is high for exactly one cycle per character: 32 pulses per frame.
  - It is never high during INIT, PWR_WAIT or IDLE.
- start while busy=1 is ignored. start on the same cycle as DONE is ignored.
- lcd_rw is always 0, including during reset.

Test Plan:
1. Reset release, sim parameters T_PWR=20, T_EN=3, T_CMD=10, T_CLR=30 -> first lcd_e rise 21 cycles after release. Four lcd_e pulses, each 3 cycles wide, with lcd_db=38,0C,01,06 and lcd_rs=0. Gap after 01 is 30 cycles. busy falls after the 06 wait.
2. RAM preloaded with addr i = 8'h41+i for i=0..31; pulse start -> 34 transfers: 80 (rs=0), 41..50 (rs=1), C0 (rs=0), 51..60 (rs=1). 32 single-cycle ram_rd pulses at ram_addr 00..1F. frame_done pulses once, then busy=0.
3. start asserted 5 cycles into a refresh and again during INIT -> no extra frame. The transfer count stays at 34.
4. BASE_ADDR=8'hF0 -> ram_addr sequence F0..FF then 00..0F. The line-1 command 8'hC0 is issued between FF and 00.
5. rst=0 for 1 cycle while lcd_e=1 mid-frame -> lcd_e=0 and busy=1 on that edge. Full init (38,0C,01,06) repeats. No data byte is sent before a new start.
6. Back-to-back start pulses, each issued one cycle after frame_done -> two identical 34-transfer frames with identical timing per frame.
